// File: rtl/s386_bist_ctrl.sv
// rtl/s386_bist_ctrl.sv - BIST sequencer for the s386 core: LFSR stimulus, MISR compaction, pass/fail
module s386_bist_ctrl #(
    parameter int          INIT_CYCLES  = 4,
    parameter int          NUM_PATTERNS = 256,
    parameter logic [5:0]  LFSR_SEED    = 6'h01,
    parameter logic [5:0]  INIT_VEC     = 6'h00
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       start,
    input  logic       abort,
    input  logic [6:0] expected_sig,
    input  logic [6:0] dut_out,
    output logic [6:0] dut_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] signature
);

    localparam int CNT_MAX = (INIT_CYCLES > NUM_PATTERNS) ? INIT_CYCLES : NUM_PATTERNS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST  = CW'(NUM_PATTERNS - 1);
    // An all-zero seed would lock the LFSR at zero.
    localparam logic [5:0] SEED = (LFSR_SEED == 6'h00) ? 6'h01 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INIT = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    lfsr_q, lfsr_d;
    logic [6:0]    misr_q, misr_d;
    logic          pass_q, pass_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [6:0]    dut_in_q, dut_in_d;

    logic [5:0]    lfsr_next;
    logic [6:0]    misr_next;

    assign lfsr_next = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
    assign misr_next = {misr_q[5:0], 1'b0} ^ (misr_q[6] ? 7'h03 : 7'h00) ^ dut_out;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pass_d  = pass_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    lfsr_d  = SEED;
                    misr_d  = 7'h00;
                    pass_d  = 1'b0;
                end
            end
            S_INIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == INIT_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    misr_d = misr_next;
                    lfsr_d = lfsr_next;
                    if (cnt_q == RUN_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        pass_d  = (misr_next == expected_sig);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d   = (state_d == S_INIT) || (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
        // v6 must stay high for the core to operate.
        dut_in_d = {1'b1, (state_d == S_RUN) ? lfsr_d : INIT_VEC};
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            lfsr_q   <= SEED;
            misr_q   <= 7'h00;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dut_in_q <= 7'h40;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            misr_q   <= misr_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dut_in_q <= dut_in_d;
        end
    end

    assign dut_in    = dut_in_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_s386_bist_ctrl.sv
// tb/tb_s386_bist_ctrl.sv - directed self-checking bench for s386_bist_ctrl
module tb_s386_bist_ctrl;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [6:0] expected_sig = 7'h00;
    logic [6:0] dut_out = 7'h00;
    logic [6:0] dut_in;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] signature;

    int n_total = 0;
    int n_pass  = 0;

    s386_bist_ctrl #(
        .INIT_CYCLES (2),
        .NUM_PATTERNS(4),
        .LFSR_SEED   (6'h01),
        .INIT_VEC    (6'h00)
    ) u_dut (
        .CK          (CK),
        .RST         (RST),
        .start       (start),
        .abort       (abort),
        .expected_sig(expected_sig),
        .dut_out     (dut_out),
        .dut_in      (dut_in),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
        chk("v6_high", {6'h00, dut_in[6]}, 7'h01);
    endtask

    logic [6:0] t2_in  [6] = '{7'h40, 7'h40, 7'h41, 7'h42, 7'h44, 7'h48};
    logic [6:0] t3_sig [7] = '{7'h00, 7'h00, 7'h00, 7'h01, 7'h03, 7'h07, 7'h0F};

    initial begin
        // T1 reset
        step();
        step();
        chk("rst_busy", {6'h0, busy}, 7'h00);
        chk("rst_done", {6'h0, done}, 7'h00);
        chk("rst_pass", {6'h0, pass}, 7'h00);
        chk("rst_sig", signature, 7'h00);
        chk("rst_dut_in", dut_in, 7'h40);
        RST = 1'b0;
        step();
        chk("idle_busy", {6'h0, busy}, 7'h00);

        // T2 zero response stream
        dut_out = 7'h00;
        expected_sig = 7'h00;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            start = 1'b0;
            chk("t2_dut_in", dut_in, t2_in[i]);
            chk("t2_busy", {6'h0, busy}, 7'h01);
            chk("t2_done_low", {6'h0, done}, 7'h00);
        end
        step();
        chk("t2_done", {6'h0, done}, 7'h01);
        chk("t2_busy_end", {6'h0, busy}, 7'h00);
        chk("t2_sig", signature, 7'h00);
        chk("t2_pass", {6'h0, pass}, 7'h01);
        chk("t2_done_dut_in", dut_in, 7'h40);
        step();
        chk("t2_idle_done", {6'h0, done}, 7'h00);

        // T3 constant 01 response, matching then mismatching golden value
        dut_out = 7'h01;
        expected_sig = 7'h0F;
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start = 1'b0;
            chk("t3_sig", signature, t3_sig[i]);
        end
        chk("t3_done", {6'h0, done}, 7'h01);
        chk("t3_pass", {6'h0, pass}, 7'h01);
        step();
        expected_sig = 7'h0E;
        start = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            start = 1'b0;
            chk("t3b_sig", signature, t3_sig[i]);
        end
        chk("t3b_done", {6'h0, done}, 7'h01);
        chk("t3b_pass", {6'h0, pass}, 7'h00);
        step();

        // T4 abort on second RUN cycle, then restart
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("t4_run1_in", dut_in, 7'h41);
        step();
        chk("t4_run2_in", dut_in, 7'h42);
        chk("t4_run2_sig", signature, 7'h01);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t4_abort_busy", {6'h0, busy}, 7'h00);
        chk("t4_abort_done", {6'h0, done}, 7'h00);
        chk("t4_abort_pass", {6'h0, pass}, 7'h00);
        chk("t4_abort_in", dut_in, 7'h40);
        step();
        chk("t4_idle_busy", {6'h0, busy}, 7'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_restart_in", dut_in, 7'h40);
        chk("t4_restart_sig", signature, 7'h00);
        chk("t4_restart_busy", {6'h0, busy}, 7'h01);
        for (int i = 0; i < 6; i++) step();
        chk("t4_done", {6'h0, done}, 7'h01);
        chk("t4_sig", signature, 7'h0F);
        step();

        // T5 start held through DONE
        start = 1'b1;
        for (int i = 0; i < 7; i++) step();
        chk("t5_done", {6'h0, done}, 7'h01);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_hold_done", {6'h0, done}, 7'h01);
            chk("t5_hold_busy", {6'h0, busy}, 7'h00);
        end
        start = 1'b0;
        step();
        chk("t5_idle_done", {6'h0, done}, 7'h00);
        chk("t5_idle_busy", {6'h0, busy}, 7'h00);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t5_rerun_busy", {6'h0, busy}, 7'h01);
        chk("t5_rerun_in", dut_in, 7'h40);

        // T6 reset mid-RUN
        step();
        step();
        step();
        chk("t6_run_in", dut_in, 7'h42);
        RST = 1'b1;
        step();
        chk("t6_busy", {6'h0, busy}, 7'h00);
        chk("t6_done", {6'h0, done}, 7'h00);
        chk("t6_pass", {6'h0, pass}, 7'h00);
        chk("t6_sig", signature, 7'h00);
        chk("t6_dut_in", dut_in, 7'h40);
        RST = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
